// File: rtl/reg_load_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : reg_load_arbiter                                               |
// | Brief   : Round-robin arbiter granting one requester per cycle onto the  |
// |           shared register-bank data bus with one-hot-low load strobes.   |
// | Option  : define ARB_LOCK_EN to add the Lock port (locked burst writes). |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module reg_load_arbiter #(
  parameter int DataWidth = 8,
  parameter int NumReq    = 4,
  parameter int NumRegs   = 8
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic [NumReq-1:0]                 Req,
  input  logic [NumReq*$clog2(NumRegs)-1:0] Addr,
  input  logic [NumReq*DataWidth-1:0]       Data,
  output logic [NumReq-1:0]                 Gnt,
  output logic [NumRegs-1:0]                LD_N,
  output logic [DataWidth-1:0]              DBus,
  output logic                              Busy,
  output logic                              AddrErr
`ifdef ARB_LOCK_EN
  ,
  input  logic [NumReq-1:0]                 Lock
`endif
);

  localparam int AddrWidth = $clog2(NumRegs);
  localparam int PtrWidth  = $clog2(NumReq);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t                r_state, w_state_next;
  logic [PtrWidth-1:0]   r_ptr, w_ptr_next;
  logic [PtrWidth-1:0]   r_win, w_win, w_idx;
  logic [NumReq-1:0]     w_elig, w_gnt;
  logic                  w_found, w_lock_hold;
  logic [AddrWidth-1:0]  w_addr;
  logic [AddrWidth:0]    w_addr_ext;
  logic [DataWidth-1:0]  w_data;
  logic [NumRegs-1:0]    w_ld_n;
  logic                  w_addr_err;

  always_comb begin
`ifdef ARB_LOCK_EN
    w_lock_hold = |(Gnt & Req & Lock);
`else
    w_lock_hold = 1'b0;
`endif
    w_elig       = Req & ~Gnt;
    w_found      = 1'b0;
    w_win        = r_win;
    w_idx        = '0;
    w_ptr_next   = r_ptr;
    w_gnt        = '0;
    w_addr       = '0;
    w_data       = '0;
    w_ld_n       = '1;
    w_state_next = IDLE;

    // A locked grantee keeps the bus; r_win still names it.
    if (w_lock_hold) begin
      w_found = 1'b1;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        w_idx = PtrWidth'((int'(r_ptr) + i) % NumReq);
        if (!w_found && w_elig[w_idx]) begin
          w_found = 1'b1;
          w_win   = w_idx;
        end
      end
      if (w_found) begin
        w_ptr_next = PtrWidth'((int'(w_win) + 1) % NumReq);
      end
    end

    if (w_found) begin
      w_gnt[w_win] = 1'b1;
      w_state_next = LOAD;
    end

    for (int i = 0; i < NumReq; i++) begin
      if (w_win == PtrWidth'(i)) begin
        w_addr = Addr[i*AddrWidth +: AddrWidth];
        w_data = Data[i*DataWidth +: DataWidth];
      end
    end

    // Extra MSB lets the range test see NumRegs when it is a power of two.
    w_addr_ext = {1'b0, w_addr};
    w_addr_err = w_found && (w_addr_ext >= (AddrWidth+1)'(NumRegs));
    for (int r = 0; r < NumRegs; r++) begin
      w_ld_n[r] = !(w_found && (w_addr_ext == (AddrWidth+1)'(r)));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      Gnt     <= '0;
      LD_N    <= '1;
      DBus    <= '0;
      AddrErr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_win   <= w_win;
      Gnt     <= w_gnt;
      LD_N    <= w_ld_n;
      AddrErr <= w_addr_err;
      if (w_found) begin
        DBus <= w_data;
      end
    end
  end

  assign Busy = (r_state == LOAD);

endmodule
`default_nettype wire

// File: tb/tb_reg_load_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_reg_load_arbiter                                            |
// | Brief   : Scoreboard bench for reg_load_arbiter (8-reg and 5-reg banks). |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_reg_load_arbiter;

  localparam int NR = 4;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  Req   = '0;
  logic [11:0] Addr  = '0;
  logic [31:0] Data  = '0;
`ifdef ARB_LOCK_EN
  logic [3:0]  Lock  = '0;
`endif
  logic [3:0]  Gnt, Gnt5;
  logic [7:0]  LD_N, DBus, DBus5;
  logic [4:0]  LD_N5;
  logic        Busy, Busy5, AddrErr, AddrErr5;

  always #5 Clk = ~Clk;

  reg_load_arbiter #(.DataWidth(8), .NumReq(4), .NumRegs(8)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Addr(Addr), .Data(Data),
    .Gnt(Gnt), .LD_N(LD_N), .DBus(DBus), .Busy(Busy), .AddrErr(AddrErr)
`ifdef ARB_LOCK_EN
    , .Lock(Lock)
`endif
  );

  // Same requesters, five-register bank: addresses 5..7 are out of range.
  reg_load_arbiter #(.DataWidth(8), .NumReq(4), .NumRegs(5)) dut5 (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Addr(Addr), .Data(Data),
    .Gnt(Gnt5), .LD_N(LD_N5), .DBus(DBus5), .Busy(Busy5), .AddrErr(AddrErr5)
`ifdef ARB_LOCK_EN
    , .Lock(Lock)
`endif
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [7:0] ld_n;
    logic [7:0] dbus;
    logic       busy;
    logic       aerr;
    logic [4:0] ld_n5;
    logic       aerr5;
  } exp_t;

  exp_t       sb[$];
  int         m_ptr  = 0;
  logic [3:0] m_gnt  = '0;
  logic [7:0] m_dbus = '0;
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] regs [8];
  int         n_loads = 0;

  // Register bank captures on the negedge inside the strobe cycle.
  always @(negedge Clk) begin
    for (int r = 0; r < 8; r++) begin
      if (LD_N[r] === 1'b0) begin
        regs[r] <= DBus;
        n_loads <= n_loads + 1;
      end
    end
  end

  // Predicts the outputs produced by the coming posedge from current inputs.
  task automatic model_edge();
    exp_t       e;
    int         w;
    int         j;
    bit         locked;
    logic [2:0] a;
    e = '0;
    w = -1;
    locked = 1'b0;
    if (Reset) begin
      m_ptr  = 0;
      m_dbus = '0;
      e.ld_n  = 8'hFF;
      e.ld_n5 = 5'h1F;
    end else begin
`ifdef ARB_LOCK_EN
      for (int i = 0; i < NR; i++) begin
        if (m_gnt[2'(i)] && Req[2'(i)] && Lock[2'(i)]) begin
          w = i;
          locked = 1'b1;
        end
      end
`endif
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (w < 0 && Req[2'(j)] && !m_gnt[2'(j)]) w = j;
      end
      if (w >= 0) begin
        a       = 3'(Addr >> (w * 3));
        m_dbus  = 8'(Data >> (w * 8));
        e.gnt   = 4'd1 << w;
        e.ld_n  = ~(8'd1 << a);
        e.busy  = 1'b1;
        e.ld_n5 = (a < 3'd5) ? ~(5'd1 << a) : 5'h1F;
        e.aerr5 = (a >= 3'd5);
        if (!locked) m_ptr = (w + 1) % NR;
      end else begin
        e.ld_n  = 8'hFF;
        e.ld_n5 = 5'h1F;
      end
    end
    e.dbus = m_dbus;
    m_gnt  = e.gnt;
    sb.push_back(e);
  endtask

  task automatic tick();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    Reset = 1'b1;
    Req   = '0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) Reset = 1'b0;
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({Gnt, LD_N, DBus, Busy, AddrErr} !== {e.gnt, e.ld_n, e.dbus, e.busy, e.aerr}) begin
        n_fail++;
        $display("FAIL reset_sb c%0d: got gnt=%b ld_n=%h dbus=%h busy=%b aerr=%b want gnt=%b ld_n=%h dbus=%h busy=%b aerr=%b",
                 c, Gnt, LD_N, DBus, Busy, AddrErr, e.gnt, e.ld_n, e.dbus, e.busy, e.aerr);
      end
    end
    n_checks++;
    if ({Gnt, LD_N, DBus, Busy, AddrErr} !== {4'b0000, 8'hFF, 8'h00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt=%b ld_n=%h dbus=%h busy=%b aerr=%b want 0000/FF/00/0/0",
               Gnt, LD_N, DBus, Busy, AddrErr);
    end
  endtask

  task automatic test_single_load();
    exp_t e;
    Req       = 4'b0010;
    Addr[5:3] = 3'd3;
    Data[15:8] = 8'hA5;
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({Gnt, LD_N, DBus, Busy} !== {e.gnt, e.ld_n, e.dbus, e.busy}) begin
      n_fail++;
      $display("FAIL single_sb: got gnt=%b ld_n=%h dbus=%h busy=%b want gnt=%b ld_n=%h dbus=%h busy=%b",
               Gnt, LD_N, DBus, Busy, e.gnt, e.ld_n, e.dbus, e.busy);
    end
    n_checks++;
    if ({Gnt, LD_N, DBus} !== {4'b0010, 8'hF7, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%b ld_n=%h dbus=%h want 0010/F7/A5", Gnt, LD_N, DBus);
    end
    Req = '0;
    model_edge();
    @(negedge Clk);
    #1;
    n_checks++;
    if (regs[3] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_reg3: got %h want A5", regs[3]);
    end
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    n_checks++;
    if ({Gnt, LD_N, DBus, Busy} !== {e.gnt, e.ld_n, e.dbus, e.busy}) begin
      n_fail++;
      $display("FAIL single_idle: got gnt=%b ld_n=%h dbus=%h busy=%b want gnt=%b ld_n=%h dbus=%h busy=%b",
               Gnt, LD_N, DBus, Busy, e.gnt, e.ld_n, e.dbus, e.busy);
    end
  endtask

  task automatic test_round_robin();
    exp_t       e;
    logic [7:0] want_ld [4];
    want_ld = '{8'hFD, 8'hFB, 8'hEF, 8'hBF};
    Reset = 1'b1;
    Req   = '0;
    tick();
    void'(sb.pop_front());
    Reset = 1'b0;
    Req   = 4'b1111;
    Addr  = {3'd6, 3'd4, 3'd2, 3'd1};
    Data  = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 5; i++) begin
      if (i == 4) Req = '0;
      tick();
      e = sb.pop_front();
      n_checks++;
      if ({Gnt, LD_N, DBus, Busy} !== {e.gnt, e.ld_n, e.dbus, e.busy}) begin
        n_fail++;
        $display("FAIL rr_sb c%0d: got gnt=%b ld_n=%h dbus=%h busy=%b want gnt=%b ld_n=%h dbus=%h busy=%b",
                 i, Gnt, LD_N, DBus, Busy, e.gnt, e.ld_n, e.dbus, e.busy);
      end
      if (i < 4) begin
        n_checks++;
        if ({Gnt, LD_N, Busy} !== {4'(4'd1 << i), want_ld[i], 1'b1}) begin
          n_fail++;
          $display("FAIL rr_grant c%0d: got gnt=%b ld_n=%h busy=%b want gnt=%b ld_n=%h busy=1",
                   i, Gnt, LD_N, Busy, 4'(4'd1 << i), want_ld[i]);
        end
      end
    end
  endtask

  task automatic test_masking();
    exp_t e;
    logic want;
    Req        = 4'b0100;
    Addr[8:6]  = 3'd2;
    Data[23:16] = 8'h5A;
`ifdef ARB_LOCK_EN
    Lock = 4'b0100;
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      e = sb.pop_front();
`ifdef ARB_LOCK_EN
      want = 1'b1;
`else
      want = ((i % 2) == 0);
`endif
      n_checks++;
      if ({Gnt, LD_N, DBus, Busy} !== {e.gnt, e.ld_n, e.dbus, e.busy} || Gnt[2] !== want) begin
        n_fail++;
        $display("FAIL mask c%0d: got gnt=%b ld_n=%h busy=%b want gnt=%b ld_n=%h busy=%b gnt2=%b",
                 i, Gnt, LD_N, Busy, e.gnt, e.ld_n, e.busy, want);
      end
    end
    Req = '0;
`ifdef ARB_LOCK_EN
    Lock = '0;
`endif
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({Gnt, Busy} !== {e.gnt, e.busy}) begin
      n_fail++;
      $display("FAIL mask_idle: got gnt=%b busy=%b want gnt=%b busy=%b", Gnt, Busy, e.gnt, e.busy);
    end
  endtask

  task automatic test_addr_err();
    exp_t       e;
    logic [2:0] addrs [2];
    addrs = '{3'd5, 3'd4};
    for (int p = 0; p < 2; p++) begin
      Req       = 4'b0001;
      Addr[2:0] = addrs[p];
      Data[7:0] = 8'hC3 + 8'(p);
      for (int c = 0; c < 2; c++) begin
        tick();
        e = sb.pop_front();
        n_checks++;
        if ({Gnt5, LD_N5, DBus5, Busy5, AddrErr5, LD_N, AddrErr} !==
            {e.gnt, e.ld_n5, e.dbus, e.busy, e.aerr5, e.ld_n, e.aerr}) begin
          n_fail++;
          $display("FAIL aerr_sb a%0d c%0d: got gnt5=%b ld_n5=%b dbus5=%h busy5=%b aerr5=%b ld_n=%h aerr=%b want %b %b %h %b %b %h %b",
                   addrs[p], c, Gnt5, LD_N5, DBus5, Busy5, AddrErr5, LD_N, AddrErr,
                   e.gnt, e.ld_n5, e.dbus, e.busy, e.aerr5, e.ld_n, e.aerr);
        end
        if (c == 0) begin
          n_checks++;
          if (p == 0 && {Gnt5, LD_N5, AddrErr5, LD_N} !== {4'b0001, 5'h1F, 1'b1, 8'hDF}) begin
            n_fail++;
            $display("FAIL aerr_oor: got gnt5=%b ld_n5=%b aerr5=%b ld_n=%h want 0001/11111/1/DF",
                     Gnt5, LD_N5, AddrErr5, LD_N);
          end else if (p == 1 && {Gnt5, LD_N5, AddrErr5} !== {4'b0001, 5'b01111, 1'b0}) begin
            n_fail++;
            $display("FAIL aerr_edge: got gnt5=%b ld_n5=%b aerr5=%b want 0001/01111/0",
                     Gnt5, LD_N5, AddrErr5);
          end
        end else begin
          n_checks++;
          if (AddrErr5 !== 1'b0 || Busy5 !== 1'b0) begin
            n_fail++;
            $display("FAIL aerr_pulse: got aerr5=%b busy5=%b want 0/0", AddrErr5, Busy5);
          end
        end
        Req = '0;
      end
    end
  endtask

  task automatic test_reset_during_load();
    exp_t e;
    int   loads0;
    Req        = 4'b0010;
    Addr[5:3]  = 3'd0;
    Data[15:8] = 8'h77;
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({Gnt, LD_N, DBus} !== {e.gnt, e.ld_n, e.dbus}) begin
      n_fail++;
      $display("FAIL rst_load_grant: got gnt=%b ld_n=%h dbus=%h want gnt=%b ld_n=%h dbus=%h",
               Gnt, LD_N, DBus, e.gnt, e.ld_n, e.dbus);
    end
    Req         = 4'b0100;
    Addr[8:6]   = 3'd5;
    Data[23:16] = 8'h99;
    Reset       = 1'b1;
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({Gnt, LD_N, DBus, Busy, AddrErr} !== {4'b0000, 8'hFF, 8'h00, 1'b0, 1'b0} ||
        {Gnt, LD_N, DBus, Busy} !== {e.gnt, e.ld_n, e.dbus, e.busy}) begin
      n_fail++;
      $display("FAIL rst_load_abort: got gnt=%b ld_n=%h dbus=%h busy=%b aerr=%b want 0000/FF/00/0/0",
               Gnt, LD_N, DBus, Busy, AddrErr);
    end
    Reset  = 1'b0;
    Req    = 4'b1111;
    loads0 = n_loads;
    model_edge();
    @(negedge Clk);
    #1;
    n_checks++;
    if (n_loads !== loads0) begin
      n_fail++;
      $display("FAIL rst_load_noload: got %0d loads want %0d", n_loads, loads0);
    end
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (Gnt !== 4'b0001 || {Gnt, LD_N, DBus} !== {e.gnt, e.ld_n, e.dbus}) begin
      n_fail++;
      $display("FAIL rst_load_ptr: got gnt=%b ld_n=%h dbus=%h want gnt=0001 ld_n=%h dbus=%h",
               Gnt, LD_N, DBus, e.ld_n, e.dbus);
    end
    Req = '0;
    tick();
    e = sb.pop_front();
    n_checks++;
    if ({Gnt, Busy} !== {e.gnt, e.busy}) begin
      n_fail++;
      $display("FAIL rst_load_idle: got gnt=%b busy=%b want gnt=%b busy=%b", Gnt, Busy, e.gnt, e.busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_load();
    test_round_robin();
    test_masking();
    test_addr_err();
    test_reset_during_load();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
